// File: rtl/iterative_circular_rotator.sv
// iterative_circular_rotator: runtime-amount circular rotate, one bit position per clock, valid/ready on both sides
module iterative_circular_rotator #(
  parameter int N = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [AW-1:0] in_amount,
  input  logic          in_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] data, data_n;
  logic [AW-1:0] count, count_n;
  logic dir, dir_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      data <= '0;
      count <= '0;
      dir <= 1'b0;
    end else begin
      state <= state_n;
      data <= data_n;
      count <= count_n;
      dir <= dir_n;
    end
  end
  always_comb begin
    state_n = state;
    data_n = data;
    count_n = count;
    dir_n = dir;
    case (state)
      IDLE: if (in_valid) begin
        data_n = in_data;
        count_n = in_amount;
        dir_n = in_dir;
        state_n = in_amount == '0 ? DONE : BUSY;
      end
      BUSY: begin
        data_n = dir ? {data[0], data[N-1:1]} : {data[N-2:0], data[N-1]};
        count_n = count - 1'b1;
        state_n = count == AW'(1) ? DONE : BUSY;
      end
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign out_data = data;
endmodule

// File: doc/iterative_circular_rotator.md
Name: iterative_circular_rotator

Overview:
- Sequential variable-amount circular rotator. Rotates an N-bit word left or right by a runtime amount, one bit position per clock.
- Sits downstream of the fixed-amount circular shift modules. It is the area-cheap replacement used where the shift amount is only known at run time and a full barrel rotator is too large.
- Valid/ready handshake on both the input and output sides.

Parameters:
- N, 8, data width in bits. Must be a power of two and at least 2.
- AW, $clog2(N), width of the rotate-amount field. Derived; do not override.

Ports:
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  request presents a word to rotate
- in_ready  output  1  block can accept a request
- in_data  input  N  word to rotate
- in_amount  input  AW  rotate distance, 0..N-1
- in_dir  input  1  0 = rotate left (toward MSB), 1 = rotate right (toward LSB)
- out_valid  output  1  out_data holds a finished result
- out_ready  input  1  consumer accepts the result
- out_data  output  N  rotated word
- busy  output  1  high in BUSY and DONE states

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While rst=1: state=IDLE, data register=0, count=0, dir register=0.
  - Output values: out_data=0, out_valid=0, in_ready=1, busy=0.
  - Asserting rst in any state, including mid-rotation or with a result pending, aborts immediately. The pending result is discarded.
- Output decoding: all outputs come straight from registers or state decode. There is no combinational path from in_* to out_*.
  - in_ready = (state==IDLE)
  - out_valid = (state==DONE)
  - busy = (state!=IDLE)
- States: IDLE, BUSY, DONE.
- IDLE:
  - On in_valid && in_ready (accept edge k): capture in_data, in_amount and in_dir.
  - If in_amount==0, go to DONE. Otherwise go to BUSY with count=in_amount.
- BUSY, on each edge:
  - Rotate the data register by exactly 1 in the captured direction.
    - Left: {d[N-2:0], d[N-1]}.
    - Right: {d[0], d[N-1:1]}.
  - Decrement count. When count was 1 before the edge, go to DONE.
  - in_valid is ignored.
- Latency:
  - For amount A>=1, out_valid is first high in the cycle after edge k+A.
  - For A=0, out_valid is first high in the cycle after edge k.
- DONE:
  - out_data is stable and out_valid=1 until out_valid && out_ready.
  - On that edge, go to IDLE.
  - in_ready stays low in DONE, so there is no same-cycle accept of a new request. Minimum spacing between accepts is A+2 cycles.
- out_data equals the data register and is held after handing off in IDLE. Consumers qualify it with out_valid only.
- Inputs that change while the block is not accepting have no effect.
- Arithmetic:
  - count is AW bits. Amounts are always below N, so count never wraps.
  - All rotation is bit-preserving: the popcount of out_data equals the popcount of the captured in_data.

Test Plan:
- N=8, in_data=10110101, in_amount=3, in_dir=0, out_ready=1 → out_data=10101101. out_valid first high in the cycle after accept edge+3. busy high during that time.
- Same input with in_dir=1 → out_data=10110110, same latency.
- in_data=00000001, amount=7, dir=1 → out_data=00000010 after 7 rotate edges. in_data=01100110, amount=0, dir=0 → out_data=01100110 with out_valid in the cycle after accept.
- Backpressure: result 10101101 pending, out_ready=0 for 5 cycles, in_valid=1 with new data → out_data stable, in_ready=0, new data not captured. Raising out_ready gives IDLE next cycle and in_ready=1.
- Reset mid-operation: accept amount=5, assert rst after 2 rotate edges → immediately out_valid=0, out_data=0, in_ready=1, busy=0. After release, a new request 11100000 left 3 → 00000111.
- Random sweep: 200 random data/amount/dir values with random out_ready stalls. Check each result against a concatenation-based reference rotation, and check latency equals max(A,0) rotate edges plus stall cycles.
